// File: rtl/uart_tx_engine.sv
// UART transmit engine: pulls characters over valid/ready and
// serialises start, data, optional parity, stop bits, plus line break.
module uart_tx_engine #(
   parameter int MAX_DATA_BITS = 9,
   parameter int CNT_W         = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_tx_clk_en,
   input  logic [CNT_W-1:0]         i_data_bits,
   input  logic [2:0]               i_parity_mode,
   input  logic                     i_double_stop,
   input  logic                     i_break_req,
   input  logic [MAX_DATA_BITS-1:0] i_data,
   input  logic                     i_data_valid,
   output logic                     o_data_ready,
   output logic                     o_tx,
   output logic                     o_busy,
   output logic                     o_frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2,
      S_BREAK
   } state_t;

   localparam logic [2:0] P_NONE  = 3'd0;
   localparam logic [2:0] P_ODD   = 3'd2;
   localparam logic [2:0] P_MARK  = 3'd3;
   localparam logic [2:0] P_SPACE = 3'd4;

   localparam logic [CNT_W-1:0] MIN_BITS = CNT_W'(5);
   localparam logic [CNT_W-1:0] MAX_BITS = CNT_W'(MAX_DATA_BITS);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [MAX_DATA_BITS-1:0] r_shreg;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         r_bits;
   logic [2:0]               r_pmode;
   logic                     r_dstop;
   logic                     r_par;
   logic                     r_brk;

   logic [CNT_W-1:0]         w_bits;
   logic [2:0]               w_pmode;
   logic                     w_last;
   logic                     w_par_bit;
   logic                     w_line;
   logic                     w_pop;
   logic                     w_done;

   always_comb begin
      w_bits = i_data_bits;
      if (i_data_bits < MIN_BITS) begin
         w_bits = MIN_BITS;
      end else if (i_data_bits > MAX_BITS) begin
         w_bits = MAX_BITS;
      end
   end

   assign w_pmode = (i_parity_mode > P_SPACE) ? P_NONE : i_parity_mode;
   assign w_last  = (r_cnt == r_bits - ONE);

   // Mark and space ignore the accumulated data parity
   always_comb begin
      w_par_bit = r_par;
      if (r_pmode == P_MARK) begin
         w_par_bit = 1'b1;
      end else if (r_pmode == P_SPACE) begin
         w_par_bit = 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_line      = 1'b1;
      w_pop       = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_break_req) begin
               w_state_nxt = S_BREAK;
            end else if (i_data_valid) begin
               w_state_nxt = S_START;
               w_pop       = 1'b1;
            end
         end
         S_START: begin
            w_line      = 1'b0;
            w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_line = r_shreg[0];
            if (w_last) begin
               w_state_nxt = (r_pmode != P_NONE) ? S_PARITY : S_STOP1;
            end
         end
         S_PARITY: begin
            w_line      = w_par_bit;
            w_state_nxt = S_STOP1;
         end
         S_STOP1: begin
            w_state_nxt = r_dstop ? S_STOP2 : S_IDLE;
            w_done      = !r_dstop && !r_brk;
         end
         S_STOP2: begin
            w_state_nxt = S_IDLE;
            w_done      = !r_brk;
         end
         S_BREAK: begin
            w_line = 1'b0;
            if (!i_break_req) begin
               w_state_nxt = S_STOP1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_bits  <= '0;
         r_pmode <= P_NONE;
         r_dstop <= 1'b0;
         r_par   <= 1'b0;
         r_brk   <= 1'b0;
      end else if (i_tx_clk_en) begin
         r_state <= w_state_nxt;
         unique case (r_state)
            S_IDLE: begin
               if (i_break_req) begin
                  r_brk   <= 1'b1;
                  r_dstop <= 1'b0;
               end else if (i_data_valid) begin
                  r_shreg <= i_data;
                  r_cnt   <= '0;
                  r_bits  <= w_bits;
                  r_pmode <= w_pmode;
                  r_dstop <= i_double_stop;
                  r_par   <= (w_pmode == P_ODD);
                  r_brk   <= 1'b0;
               end
            end
            S_DATA: begin
               r_shreg <= r_shreg >> 1;
               r_par   <= r_par ^ r_shreg[0];
               r_cnt   <= r_cnt + ONE;
            end
            default: begin
            end
         endcase
      end
   end

   assign o_tx         = w_line;
   assign o_busy       = (r_state != S_IDLE);
   assign o_data_ready = w_pop && i_tx_clk_en && !reset;
   assign o_frame_done = w_done && i_tx_clk_en && !reset;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: bit streams, pops and frame pulses
// are checked against hand-computed vectors.
module tb_uart_tx_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_clk_en;
   logic [3:0] data_bits;
   logic [2:0] parity_mode;
   logic       double_stop;
   logic       break_req;
   logic [8:0] data;
   logic       data_valid;
   logic       data_ready;
   logic       tx;
   logic       busy;
   logic       frame_done;

   int total = 0;
   int bad   = 0;

   logic [8:0]  fifo[$];
   logic        q_bits[$];
   int          pop_at[$];
   int          done_at[$];
   int unsigned div = 16;
   int unsigned sc  = 0;
   int          strobes = 0;
   int          pops = 0;
   int          dones = 0;
   logic        pend_pop = 1'b0;

   uart_tx_engine #(
      .MAX_DATA_BITS(9),
      .CNT_W        (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_tx_clk_en  (tx_clk_en),
      .i_data_bits  (data_bits),
      .i_parity_mode(parity_mode),
      .i_double_stop(double_stop),
      .i_break_req  (break_req),
      .i_data       (data),
      .i_data_valid (data_valid),
      .o_data_ready (data_ready),
      .o_tx         (tx),
      .o_busy       (busy),
      .o_frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // FIFO model, strobe generator and line monitor
   always @(negedge clk) begin
      if (pend_pop) begin
         if (fifo.size() > 0) fifo.delete(0);
         pend_pop = 1'b0;
      end
      data_valid = (fifo.size() > 0);
      data = data_valid ? fifo[0] : 9'd0;
      if (div <= 1) begin
         tx_clk_en = 1'b1;
      end else begin
         sc = (sc + 1 >= div) ? 0 : sc + 1;
         tx_clk_en = (sc == 0);
      end
      #1;
      if (tx_clk_en) begin
         strobes++;
         if (busy) q_bits.push_back(tx);
      end
      if (data_ready) begin
         pops++;
         pend_pop = 1'b1;
         pop_at.push_back(strobes);
      end
      if (frame_done) begin
         dones++;
         done_at.push_back(strobes);
      end
   end

   function automatic logic [63:0] pack_bits();
      logic [63:0] v = '0;
      foreach (q_bits[i]) v = {v[62:0], q_bits[i]};
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (dones < target && n < budget) begin
         tick();
         n++;
      end
      if (dones < target) begin
         total++;
         bad++;
         $display("FAIL done_timeout got=%0d want=%0d", dones, target);
      end
   endtask

   task automatic wait_pop(input int target, input int budget);
      int n = 0;
      while (pops < target && n < budget) begin
         tick();
         n++;
      end
      if (pops < target) begin
         total++;
         bad++;
         $display("FAIL pop_timeout got=%0d want=%0d", pops, target);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL idle_timeout busy=%0b want=0", busy);
      end
   endtask

   task automatic wait_strobes(input int k);
      int target = strobes + k;
      int n = 0;
      while (strobes < target && n < k * 20 + 20) begin
         tick();
         n++;
      end
   endtask

   task automatic run_frame(input logic [3:0] nb, input logic [2:0] pm,
                            input logic ds, input logic [8:0] d);
      int d0;
      data_bits   = nb;
      parity_mode = pm;
      double_stop = ds;
      q_bits.delete();
      d0 = dones;
      fifo.push_back(d);
      wait_done(d0 + 1, 800);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      data_bits = 4'd8;
      fifo.push_back(9'h055);
      repeat (40) tick();
      total++;
      if (tx !== 1'b1) begin
         bad++;
         $display("FAIL reset_tx got=%0b want=1", tx);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy got=%0b want=0", busy);
      end
      total++;
      if (data_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready got=%0b want=0", data_ready);
      end
      total++;
      if (frame_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_done got=%0b want=0", frame_done);
      end
      total++;
      if (pops !== 0) begin
         bad++;
         $display("FAIL reset_nopop got=%0d want=0", pops);
      end
      fifo.delete();
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_8n1();
      int p0 = pops;
      int d0 = dones;
      run_frame(4'd8, 3'd0, 1'b0, 9'h055);
      total++;
      if (q_bits.size() !== 10) begin
         bad++;
         $display("FAIL 8n1_len got=%0d want=10", q_bits.size());
      end
      total++;
      if (pack_bits() !== 64'b0101010101) begin
         bad++;
         $display("FAIL 8n1_bits got=%b want=0101010101", pack_bits());
      end
      total++;
      if (pops - p0 !== 1) begin
         bad++;
         $display("FAIL 8n1_pops got=%0d want=1", pops - p0);
      end
      total++;
      if (dones - d0 !== 1) begin
         bad++;
         $display("FAIL 8n1_dones got=%0d want=1", dones - d0);
      end
      tick();
      total++;
      if (tx !== 1'b1) begin
         bad++;
         $display("FAIL 8n1_idle_tx got=%0b want=1", tx);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL 8n1_idle_busy got=%0b want=0", busy);
      end
   endtask

   task automatic test_parity();
      run_frame(4'd7, 3'd1, 1'b1, 9'h003);
      total++;
      if (q_bits.size() !== 11 || pack_bits() !== 64'b01100000011) begin
         bad++;
         $display("FAIL 7e2 got=%b len=%0d want=01100000011", pack_bits(), q_bits.size());
      end
      run_frame(4'd7, 3'd2, 1'b0, 9'h003);
      total++;
      if (q_bits.size() !== 10 || pack_bits() !== 64'b0110000011) begin
         bad++;
         $display("FAIL 7o1 got=%b len=%0d want=0110000011", pack_bits(), q_bits.size());
      end
      run_frame(4'd5, 3'd3, 1'b0, 9'h000);
      total++;
      if (q_bits.size() !== 8 || pack_bits() !== 64'b00000011) begin
         bad++;
         $display("FAIL 5m1 got=%b len=%0d want=00000011", pack_bits(), q_bits.size());
      end
      run_frame(4'd5, 3'd4, 1'b0, 9'h01F);
      total++;
      if (q_bits.size() !== 8 || pack_bits() !== 64'b01111101) begin
         bad++;
         $display("FAIL 5s1 got=%b len=%0d want=01111101", pack_bits(), q_bits.size());
      end
      run_frame(4'd5, 3'd5, 1'b0, 9'h015);
      total++;
      if (q_bits.size() !== 7 || pack_bits() !== 64'b0101011) begin
         bad++;
         $display("FAIL mode5_none got=%b len=%0d want=0101011", pack_bits(), q_bits.size());
      end
   endtask

   task automatic test_clamp();
      run_frame(4'd2, 3'd0, 1'b0, 9'h1F5);
      total++;
      if (q_bits.size() !== 7) begin
         bad++;
         $display("FAIL clamp_lo_len got=%0d want=7", q_bits.size());
      end
      total++;
      if (pack_bits() !== 64'b0101011) begin
         bad++;
         $display("FAIL clamp_lo_bits got=%b want=0101011", pack_bits());
      end
      run_frame(4'd15, 3'd0, 1'b0, 9'h100);
      total++;
      if (q_bits.size() !== 11) begin
         bad++;
         $display("FAIL clamp_hi_len got=%0d want=11", q_bits.size());
      end
      total++;
      if (pack_bits() !== 64'b00000000011) begin
         bad++;
         $display("FAIL clamp_hi_bits got=%b want=00000000011", pack_bits());
      end
   endtask

   task automatic test_break();
      int p0 = pops;
      int d0 = dones;
      data_bits   = 4'd8;
      parity_mode = 3'd0;
      double_stop = 1'b0;
      q_bits.delete();
      fifo.push_back(9'h0A5);
      wait_pop(p0 + 1, 200);
      double_stop = 1'b1;
      data_bits   = 4'd5;
      wait_strobes(2);
      break_req = 1'b1;
      wait_done(d0 + 1, 400);
      wait_strobes(3);
      break_req = 1'b0;
      wait_idle(200);
      wait_strobes(3);
      total++;
      if (q_bits.size() !== 14) begin
         bad++;
         $display("FAIL break_len got=%0d want=14", q_bits.size());
      end
      total++;
      if (pack_bits() !== 64'b01010010110001) begin
         bad++;
         $display("FAIL break_bits got=%b want=01010010110001", pack_bits());
      end
      total++;
      if (dones - d0 !== 1) begin
         bad++;
         $display("FAIL break_dones got=%0d want=1", dones - d0);
      end
      double_stop = 1'b0;
      data_bits   = 4'd8;
   endtask

   task automatic test_back_to_back();
      int p0;
      int d0;
      div = 1;
      tick();
      data_bits   = 4'd8;
      parity_mode = 3'd0;
      double_stop = 1'b0;
      q_bits.delete();
      pop_at.delete();
      done_at.delete();
      p0 = pops;
      d0 = dones;
      fifo.push_back(9'h001);
      fifo.push_back(9'h080);
      fifo.push_back(9'h0FF);
      wait_done(d0 + 3, 200);
      repeat (5) tick();
      total++;
      if (pops - p0 !== 3) begin
         bad++;
         $display("FAIL b2b_pops got=%0d want=3", pops - p0);
      end
      total++;
      if (dones - d0 !== 3) begin
         bad++;
         $display("FAIL b2b_dones got=%0d want=3", dones - d0);
      end
      total++;
      if (q_bits.size() !== 30 ||
          pack_bits() !== 64'b010000000100000000110111111111) begin
         bad++;
         $display("FAIL b2b_bits got=%b len=%0d", pack_bits(), q_bits.size());
      end
      total++;
      if (pop_at.size() < 3 || done_at.size() < 3) begin
         bad++;
         $display("FAIL b2b_events pops=%0d dones=%0d want=3", pop_at.size(), done_at.size());
      end else if (pop_at[1] - done_at[0] !== 1 || pop_at[2] - done_at[1] !== 1) begin
         bad++;
         $display("FAIL b2b_gap got=%0d,%0d want=1,1",
                  pop_at[1] - done_at[0], pop_at[2] - done_at[1]);
      end
      total++;
      if (done_at.size() < 3 || pop_at.size() < 1 || done_at[2] - pop_at[0] !== 32) begin
         bad++;
         $display("FAIL b2b_span got=%0d want=32",
                  (done_at.size() >= 3 && pop_at.size() >= 1) ? done_at[2] - pop_at[0] : -1);
      end
      div = 16;
      sc  = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      int p0;
      int d0;
      data_bits   = 4'd8;
      parity_mode = 3'd0;
      double_stop = 1'b0;
      p0 = pops;
      fifo.push_back(9'h0FF);
      wait_pop(p0 + 1, 200);
      wait_strobes(4);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_busy_before got=%0b want=1", busy);
      end
      p0 = pops;
      d0 = dones;
      reset = 1'b1;
      tick();
      total++;
      if (tx !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_tx got=%0b want=1", tx);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_busy got=%0b want=0", busy);
      end
      reset = 1'b0;
      wait_strobes(20);
      total++;
      if (pops !== p0) begin
         bad++;
         $display("FAIL mid_recover_pops got=%0d want=%0d", pops, p0);
      end
      total++;
      if (dones !== d0) begin
         bad++;
         $display("FAIL mid_recover_dones got=%0d want=%0d", dones, d0);
      end
      total++;
      if (tx !== 1'b1) begin
         bad++;
         $display("FAIL mid_recover_tx got=%0b want=1", tx);
      end
   endtask

   initial begin
      reset       = 1'b1;
      tx_clk_en   = 1'b0;
      data_bits   = 4'd8;
      parity_mode = 3'd0;
      double_stop = 1'b0;
      break_req   = 1'b0;
      data        = 9'd0;
      data_valid  = 1'b0;
      test_reset();
      test_8n1();
      test_parity();
      test_clamp();
      test_break();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
